tl_cycle_counter: RTL and testbench
===================================

TL_CYCLE_COUNTER -- requirements
Module: tl_cycle_counter

Interface
REQ-001 Parameter NORM_LEN, default 30, gives the cycle length in ticks when no pedestrian phase is active (counter 0..29).
REQ-002 Parameter PED_LEN, default 34, gives the cycle length in ticks when the pedestrian phase is active (counter 0..33).
REQ-003 Parameter DB_CYCLES, default 4, gives the number of consecutive clk cycles a synchronized button level must hold before it is accepted.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port tick, input, 1 bit: one-clk-wide timebase pulse, synchronous to clk; the counter advances only on clk edges where tick=1.
REQ-007 Port ped_btn, input, 1 bit: raw pedestrian button, asynchronous to clk, active-high.
REQ-008 Port counter, output, 6 bits: position within the current light cycle, registered; feeds the downstream phase-enable decoder.
REQ-009 Port ped, output, 1 bit: pedestrian mode of the current cycle, registered, constant for a whole cycle; feeds the downstream decoder.
REQ-010 Port ped_pending, output, 1 bit: an accepted press is waiting for the next cycle boundary.
REQ-011 Port cycle_start, output, 1 bit: registered one-clk pulse marking that counter has just been loaded with 0 by a wrap.

Function
REQ-012 ped_btn SHALL pass through a 2-flop synchronizer (s1, then s2) before any other use.
REQ-013 Debounce SHALL use a level register btn_db and a run counter: on each clk where s2 != btn_db, the run counter increments, or, if it equals DB_CYCLES-1, btn_db <= s2 and the run counter clears; where s2 == btn_db, the run counter clears.
REQ-014 An s2 pulse shorter than DB_CYCLES clk cycles SHALL NOT change btn_db.
REQ-015 A press SHALL be accepted on the clk edge where btn_db transitions 0->1; falling transitions SHALL be ignored.
REQ-016 ped_pending SHALL be observed high after exactly DB_CYCLES+2 clk edges, counting the first edge that samples ped_btn high; with the default DB_CYCLES that is the 6th edge.
REQ-017 last SHALL be PED_LEN-1 when ped=1 and NORM_LEN-1 when ped=0.
REQ-018 On tick=1 with counter != last, counter SHALL increment by 1; on tick=0, counter SHALL hold.
REQ-019 On tick=1 with counter == last (a wrap), counter SHALL load 0 and ped SHALL load (ped_pending OR press accepted this edge); ped_pending SHALL clear.
REQ-020 On an edge that is not a wrap, ped_pending SHALL load (ped_pending OR press accepted this edge).
REQ-021 Further presses while ped_pending=1 or ped=1 SHALL NOT extend or queue more than one pedestrian cycle.
REQ-022 cycle_start SHALL be 1 for exactly the one clk following a wrap edge, and 0 otherwise.
REQ-023 counter SHALL never exceed PED_LEN-1; any out-of-range value SHALL be treated as last and wrap on the next tick.
REQ-024 The block SHALL require NORM_LEN and PED_LEN in the range 2..64 and DB_CYCLES >= 1.

Reset
REQ-025 While rst=1, the block SHALL immediately (asynchronously) hold: counter=0, ped=0, ped_pending=0, cycle_start=0, s1=s2=0, btn_db=0, run counter=0.
REQ-026 After rst deasserts, counter SHALL advance from 0 on the first tick; no cycle_start pulse SHALL be generated for the reset-initiated cycle.
REQ-027 Asserting rst mid-cycle SHALL discard any pending press and any in-progress debounce.

Verification
REQ-028 rst, then tick every 10 clk with ped_btn=0 -> counter counts 0..29, wraps to 0, cycle_start pulses once per 30 ticks, ped stays 0.
REQ-029 ped_btn high for 20 clk while counter=5 -> ped_pending=1 on the 6th edge; at the wrap from 29, ped=1, ped_pending=0; the next cycle wraps from 33; the following cycle has ped=0.
REQ-030 ped_btn pulses of 1, 2 and 3 clk (DB_CYCLES=4) -> ped_pending stays 0 throughout.
REQ-031 Press accepted on the same edge as the wrap (counter=29, tick=1) -> ped=1 for the new cycle, ped_pending=0 afterwards.
REQ-032 rst asserted at counter=17 with ped_pending=1 -> all outputs 0 immediately, without waiting for a clk edge; the first post-reset cycle has ped=0.
REQ-033 tick held low for 100 clk at counter=12 -> counter remains 12, and a press during that window still sets ped_pending.

Source files
------------

// File: rtl/tl_cycle_counter.sv
// Traffic-light cycle position counter with a synchronized, debounced pedestrian
// request that switches the next cycle to the longer pedestrian length.
module tl_cycle_counter #(
  parameter int NORM_LEN  = 30,
  parameter int PED_LEN   = 34,
  parameter int DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_btn,
  output logic [5:0] counter,
  output logic       ped,
  output logic       ped_pending,
  output logic       cycle_start
);

  // Legal ranges: NORM_LEN and PED_LEN in 2..64, DB_CYCLES >= 1.
  localparam int RUN_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(DB_CYCLES - 1);
  localparam logic [5:0]       NORM_LST = 6'(NORM_LEN - 1);
  localparam logic [5:0]       PED_LST  = 6'(PED_LEN - 1);

  logic             s1;
  logic             s2;
  logic             btn_db;
  logic [RUN_W-1:0] run_cnt;

  logic [5:0] last;
  logic       wrap;
  logic       db_flip;
  logic       press;

  always_comb begin
    last    = ped ? PED_LST : NORM_LST;
    // Anything at or beyond last wraps, so a corrupted count recovers on the next tick.
    wrap    = tick && (counter >= last);
    db_flip = (s2 != btn_db) && (run_cnt == RUN_MAX);
    press   = db_flip && s2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      btn_db  <= 1'b0;
      run_cnt <= '0;
    end else begin
      s1 <= ped_btn;
      s2 <= s1;
      if (s2 != btn_db) begin
        if (db_flip) begin
          btn_db  <= s2;
          run_cnt <= '0;
        end else begin
          run_cnt <= run_cnt + RUN_W'(1);
        end
      end else begin
        run_cnt <= '0;
      end
    end
  end

  // A press landing on the wrap edge goes straight into ped for the new cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter     <= '0;
      ped         <= 1'b0;
      ped_pending <= 1'b0;
      cycle_start <= 1'b0;
    end else begin
      cycle_start <= wrap;
      if (wrap) begin
        counter     <= '0;
        ped         <= ped_pending | press;
        ped_pending <= 1'b0;
      end else begin
        if (tick) counter <= counter + 6'd1;
        ped_pending <= ped_pending | press;
      end
    end
  end

endmodule

// File: tb/tb_tl_cycle_counter.sv
// Bench for tl_cycle_counter: directed scenarios plus random tick/button traffic,
// all compared every cycle against a sample-history reference model.
module tb_tl_cycle_counter;

  localparam int NORM_LEN = 30;
  localparam int PED_LEN  = 34;
  localparam int DB       = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       ped_btn;
  logic [5:0] counter;
  logic       ped;
  logic       ped_pending;
  logic       cycle_start;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_cnt;
  bit m_ped;
  bit m_pend;
  bit m_cs;
  bit m_db;
  bit raw_q[$];
  bit s2_q[$];

  tl_cycle_counter #(
    .NORM_LEN (NORM_LEN),
    .PED_LEN  (PED_LEN),
    .DB_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .ped_btn    (ped_btn),
    .counter    (counter),
    .ped        (ped),
    .ped_pending(ped_pending),
    .cycle_start(cycle_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_ped  = 0;
    m_pend = 0;
    m_cs   = 0;
    m_db   = 0;
    raw_q.delete();
    s2_q.delete();
  endtask

  // One rising edge: the debounced level flips once the last DB synchronized
  // samples all disagree with it; the synchronized sample is the raw input two edges back.
  task automatic model_edge();
    bit s2v;
    bit acc;
    bit all_diff;
    int last;
    bit wrap;
    acc = 0;
    s2v = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : 1'b0;
    s2_q.push_back(s2v);
    if (s2_q.size() >= DB) begin
      all_diff = 1;
      for (int i = s2_q.size() - DB; i < s2_q.size(); i++)
        if (s2_q[i] == m_db) all_diff = 0;
      if (all_diff) begin
        m_db = ~m_db;
        acc  = m_db;
      end
    end
    raw_q.push_back(ped_btn);
    while (raw_q.size() > 16) void'(raw_q.pop_front());
    while (s2_q.size() > 16) void'(s2_q.pop_front());
    last = m_ped ? PED_LEN - 1 : NORM_LEN - 1;
    wrap = tick && (m_cnt == last);
    if (wrap) begin
      m_cnt  = 0;
      m_ped  = m_pend | acc;
      m_pend = 0;
    end else begin
      if (tick) m_cnt = m_cnt + 1;
      m_pend = m_pend | acc;
    end
    m_cs = wrap;
  endtask

  task automatic check_all();
    check("counter",     32'(counter),     32'(m_cnt));
    check("ped",         32'(ped),         32'(m_ped));
    check("ped_pending", 32'(ped_pending), 32'(m_pend));
    check("cycle_start", 32'(cycle_start), 32'(m_cs));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic cyc(input bit t, input bit b);
    tick    = t;
    ped_btn = b;
    step();
  endtask

  task automatic advance_to(input int target);
    for (int i = 0; i < 200; i++) begin
      if (m_cnt == target) break;
      cyc(1'b1, 1'b0);
    end
    check("advance_to", 32'(counter), 32'(target));
  endtask

  int hold;
  bit bval;

  initial begin
    rst     = 1'b1;
    tick    = 1'b0;
    ped_btn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // plain counting, tick every 10 clk, no presses
    for (int k = 0; k < 35; k++)
      for (int j = 0; j < 10; j++) cyc(j == 9, 1'b0);
    check("plain_cnt", 32'(counter), 32'd5);
    check("plain_ped", 32'(ped), 32'd0);

    // press while counter=5: pending on 6th edge, ped cycle of 34, then back to normal
    advance_to(5);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1);
      if (i == 4) check("pend_edge5", 32'(ped_pending), 32'd0);
      if (i == 5) check("pend_edge6", 32'(ped_pending), 32'd1);
    end
    advance_to(29);
    cyc(1'b1, 1'b0);
    check("wrap29_ped", 32'(ped), 32'd1);
    check("wrap29_pend", 32'(ped_pending), 32'd0);
    check("wrap29_cs", 32'(cycle_start), 32'd1);
    advance_to(33);
    cyc(1'b1, 1'b0);
    check("wrap33_cnt", 32'(counter), 32'd0);
    check("wrap33_ped", 32'(ped), 32'd0);

    // short pulses must be rejected by the debouncer
    for (int w = 1; w <= 3; w++) begin
      for (int i = 0; i < w; i++) cyc($urandom_range(0, 1) == 1, 1'b1);
      for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0);
    end
    check("short_pulse", 32'(ped_pending), 32'd0);

    // press accepted on exactly the wrap edge
    advance_to(29);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    check("samewrap_cnt", 32'(counter), 32'd0);
    check("samewrap_ped", 32'(ped), 32'd1);
    check("samewrap_pend", 32'(ped_pending), 32'd0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0);

    // async reset mid-cycle with a pending press
    advance_to(17);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1);
    check("pre_rst_pend", 32'(ped_pending), 32'd1);
    ped_btn = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    rst = 1'b0;
    advance_to(29);
    cyc(1'b1, 1'b0);
    check("post_rst_ped", 32'(ped), 32'd0);

    // tick low for 100 clk at counter=12, press inside the window
    advance_to(12);
    for (int i = 0; i < 100; i++) cyc(1'b0, (i >= 40) && (i < 60));
    check("stall_cnt", 32'(counter), 32'd12);
    check("stall_pend", 32'(ped_pending), 32'd1);

    // random traffic
    hold = 0;
    bval = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        bval = ~bval;
        hold = $urandom_range(1, 8);
      end
      hold--;
      cyc($urandom_range(0, 2) == 0, bval);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
